// File: rtl/pattern_detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package pattern_detector_pkg;

  // Legal pattern lengths.
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;

  // Width of the fill counter, which must hold the values 0..pat_w.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/pattern_detector_sat.sv
// sat_counter: counter with a clear input that stops at its maximum value.
// Reset is synchronous and active-low. Clear takes priority over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear first, then increment only while below the maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: serial bit-pattern matcher with a registered match pulse.
// A match is declared when the last PAT_W valid bits equal PATTERN (the
// first-received bit is the MSB) and at least PAT_W bits have been collected
// since reset (or since the previous match when OVERLAP=0).
// Build option: define PATTERN_DETECTOR_CNT_EN to get a saturating hit
// counter on hit_cnt; without it hit_cnt is tied to 0 and cnt_clr is unused.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int                   PAT_W   = 4,
  parameter logic [PAT_W_MAX-1:0] PATTERN = 4'b1011,
  parameter int                   OVERLAP = 1,
  parameter int                   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             a_valid,
  input  logic             cnt_clr,
  output logic             w,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int               FILL_W    = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [PAT_W-1:0] PAT       = PATTERN[PAT_W-1:0];

  // Elaboration-time parameter checks.
  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("pattern_detector: PAT_W=%0d outside %0d..%0d", PAT_W, PAT_W_MIN, PAT_W_MAX);
  end
  if ((PATTERN >> PAT_W) != '0) begin : g_bad_pattern
    $error("pattern_detector: PATTERN does not fit in PAT_W=%0d bits", PAT_W);
  end

  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [FILL_W-1:0] fill_inc;
  logic              w_q;
  logic              w_d;
  logic              match;

  // Shift in valid bits, track how many bits count toward a match, detect.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    fill_inc = fill_q;
    match    = 1'b0;
    if (a_valid) begin
      hist_d   = {hist_q[PAT_W-2:0], a};
      fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      match    = (hist_d == PAT) && (fill_inc == FILL_FULL);
      // Non-overlapping mode starts collecting a fresh PAT_W bits after a hit.
      fill_d   = (match && (OVERLAP == 0)) ? '0 : fill_inc;
    end
    w_d = match;
  end

  // History, fill and match-pulse registers; reset discards any partial pattern.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      w_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      w_q    <= w_d;
    end
  end

  assign w = w_q;

`ifdef PATTERN_DETECTOR_CNT_EN
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .cnt (hit_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Testbench for pattern_detector: two instances (overlapping / CNT_W=8 and
// non-overlapping / CNT_W=2) share stimulus and are compared every cycle
// against a queue-based reference model, plus directed scenario checks.
module tb_pattern_detector;

  localparam int         PAT_W = 4;
  localparam logic [3:0] PAT   = 4'b1011;
`ifdef PATTERN_DETECTOR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic       a_valid;
  logic       cnt_clr;
  logic       w_ov;
  logic       w_no;
  logic [7:0] cnt_ov;
  logic [1:0] cnt_no;

  always #5 clk = ~clk;

  pattern_detector #(
    .PAT_W(4), .PATTERN(32'b1011), .OVERLAP(1), .CNT_W(8)
  ) dut_ov (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .cnt_clr(cnt_clr),
    .w(w_ov), .hit_cnt(cnt_ov)
  );

  pattern_detector #(
    .PAT_W(4), .PATTERN(32'b1011), .OVERLAP(0), .CNT_W(2)
  ) dut_no (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .cnt_clr(cnt_clr),
    .w(w_no), .hit_cnt(cnt_no)
  );

  int n_checks  = 0;
  int n_err     = 0;
  int cyc       = 0;
  int pulses_ov = 0;
  int pulses_no = 0;

  // Reference model: recent valid bits (since reset, or since last hit when
  // non-overlapping), the expected pulse and the expected count.
  bit q_ov[$];
  bit q_no[$];
  bit ew_ov, ew_no;
  int ec_ov, ec_no;

  function automatic bit tail_match(input bit q[$]);
    logic [3:0] v;
    v = '0;
    if (q.size() < PAT_W) return 1'b0;
    for (int i = 0; i < PAT_W; i++) v = {v[2:0], q[q.size() - PAT_W + i]};
    return v == PAT;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit ai, input bit vi, input bit ci, input bit ri);
    a = ai; a_valid = vi; cnt_clr = ci; rst = ri;
    @(posedge clk);
    cyc++;
    if (!ri) begin
      q_ov.delete(); q_no.delete();
      ew_ov = 1'b0; ew_no = 1'b0; ec_ov = 0; ec_no = 0;
    end else begin
      ew_ov = 1'b0; ew_no = 1'b0;
      if (vi) begin
        q_ov.push_back(ai);
        if (q_ov.size() > PAT_W) void'(q_ov.pop_front());
        q_no.push_back(ai);
        if (q_no.size() > PAT_W) void'(q_no.pop_front());
        ew_ov = tail_match(q_ov);
        ew_no = tail_match(q_no);
        if (ew_no) q_no.delete();
      end
      if (ci) begin
        ec_ov = 0; ec_no = 0;
      end else begin
        if (ew_ov && ec_ov < 255) ec_ov++;
        if (ew_no && ec_no < 3) ec_no++;
      end
    end
    #1;
    chk("w_ov",   32'(w_ov),   32'(ew_ov));
    chk("w_no",   32'(w_no),   32'(ew_no));
    chk("cnt_ov", 32'(cnt_ov), CNT_EN ? 32'(ec_ov) : 32'd0);
    chk("cnt_no", 32'(cnt_no), CNT_EN ? 32'(ec_no) : 32'd0);
    pulses_ov += int'(w_ov);
    pulses_no += int'(w_no);
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) step(bits[n-1-i], 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    pulses_ov = 0;
    pulses_no = 0;
  endtask

  initial begin
    a = 1'b0; a_valid = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_w",   32'(w_ov),   32'd0);
    chk("reset_cnt", 32'(cnt_ov), 32'd0);

    // Single match 1,0,1,1
    do_reset();
    send(16'b1011, 4);
    chk("single_w_after_4th", 32'(w_ov), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_pulses", 32'(pulses_ov), 32'd1);
    chk("single_cnt",    32'(cnt_ov), CNT_EN ? 32'd1 : 32'd0);

    // Overlapping vs non-overlapping on 1,0,1,1,0,1,1
    do_reset();
    send(16'b1011011, 7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovl_pulses",   32'(pulses_ov), 32'd2);
    chk("novl_pulses",  32'(pulses_no), 32'd1);
    chk("ovl_cnt",      32'(cnt_ov), CNT_EN ? 32'd2 : 32'd0);
    chk("novl_cnt",     32'(cnt_no), CNT_EN ? 32'd1 : 32'd0);

    // Gap in a_valid keeps history
    do_reset();
    send(16'b10, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("gap_pulses_before", 32'(pulses_ov), 32'd0);
    send(16'b11, 2);
    chk("gap_w_final", 32'(w_ov), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("gap_pulses", 32'(pulses_ov), 32'd1);

    // Reset mid-pattern discards partial sequence
    do_reset();
    send(16'b101, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send(16'b1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_pulses", 32'(pulses_ov), 32'd0);
    chk("midrst_cnt",    32'(cnt_ov), 32'd0);

    // Saturation of the 2-bit counter, then clear colliding with a match
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(16'b1011, 4);
      chk("sat_cnt_no", 32'(cnt_no), CNT_EN ? ((k < 3) ? 32'(k + 1) : 32'd3) : 32'd0);
    end
    chk("sat_cnt_ov", 32'(cnt_ov), CNT_EN ? 32'd5 : 32'd0);
    send(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_match_w",   32'(w_no),   32'd1);
    chk("clr_match_cnt", 32'(cnt_no), 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter PATTERN, default 4'b1011, PAT_W-bit target pattern; the first-received bit is the MSB.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping matches, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, width of the hit counter.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port a, input, 1 bit: serial data bit.
REQ-008 SHALL have port a_valid, input, 1 bit: a is sampled only when high.
REQ-009 SHALL have port cnt_clr, input, 1 bit: synchronous hit-counter clear.
REQ-010 SHALL have port w, output, 1 bit: registered one-cycle match pulse.
REQ-011 SHALL have port hit_cnt, output, CNT_W bits: saturating match count.

Function
REQ-012 SHALL keep a PAT_W-bit history register; on an edge with a_valid=1: hist_next = {hist[PAT_W-2:0], a}.
REQ-013 SHALL keep a fill counter (0..PAT_W, saturating at PAT_W), incremented on each valid bit.
REQ-014 SHALL declare a match on a valid edge when hist_next == PATTERN and fill_next == PAT_W.
REQ-015 SHALL register the match into w, so that w is high for exactly the cycle following the edge that sampled the completing bit. Latency is 1 cycle.
REQ-016 SHALL drive w=0 for any cycle following an edge with a_valid=0; gaps in a_valid neither shift, clear nor alter history.
REQ-017 When OVERLAP=1, SHALL leave fill unchanged at a match, so a suffix of the matched bits can start the next match.
REQ-018 When OVERLAP=0, SHALL reset fill to 0 at a match; PAT_W further valid bits are needed before the next match.
REQ-019 SHALL increment hit_cnt by 1 per match and hold it at 2^CNT_W-1 once saturated; it never wraps.
REQ-020 On an edge with cnt_clr=1, SHALL set hit_cnt to 0; clear wins over a simultaneous match (count 0 afterwards; w still pulses).

Reset
REQ-021 When rst=0 at an edge, SHALL clear hist, fill, w and hit_cnt to 0.
REQ-022 Reset mid-pattern SHALL discard any partial sequence; detection restarts from an empty history.
REQ-023 Inputs a, a_valid and cnt_clr SHALL be ignored during reset.

Configuration
REQ-024 Macro PATTERN_DETECTOR_CNT_EN: when defined, SHALL implement the hit counter per REQ-019/020.
REQ-025 When PATTERN_DETECTOR_CNT_EN is undefined, SHALL keep the hit_cnt port, drive it constantly to 0 and ignore cnt_clr; the w behaviour SHALL be identical in both builds.

Structure
REQ-026 Package pattern_detector_pkg SHALL hold PAT_W_MIN=2, PAT_W_MAX=32 and the fill-counter width function clog2(PAT_W+1).
REQ-027 SHALL instantiate one sub-module, sat_counter (parameter WIDTH; ports clk, rst, inc, clr, cnt), for hit_cnt.
REQ-028 SHALL elaborate-time check PAT_W range, and SHALL check that PATTERN fits in PAT_W bits.

Verification (PAT_W=4, PATTERN=4'b1011, CNT_W=8 unless noted)
REQ-029 Bits 1,0,1,1, valid every cycle -> w high exactly one cycle after the 4th sampling edge; hit_cnt=1.
REQ-030 OVERLAP=1, stream 1,0,1,1,0,1,1 -> two w pulses (after bits 4 and 7); hit_cnt=2. OVERLAP=0, same stream -> one pulse; hit_cnt=1.
REQ-031 Bits 1,0 then 3 cycles a_valid=0 then bits 1,1 -> one w pulse after the final valid bit; w=0 during the gap.
REQ-032 Bits 1,0,1, then rst=0 for 1 cycle, then bit 1 -> no w pulse; hit_cnt=0.
REQ-033 CNT_W=2, 5 non-overlapping matches -> hit_cnt = 1,2,3,3,3. A match with cnt_clr=1 on the same edge -> hit_cnt=0 and w pulses.
REQ-034 Build without PATTERN_DETECTOR_CNT_EN, rerun REQ-030 -> identical w trace; hit_cnt=0 throughout.
